// File: rtl/alu_issue_arbiter.sv
// Round-robin issue of two requesters onto one shared combinational ALU. Holds operands for a
// per-op latency, captures dst/sro into a response register and owns the architectural SR.
module alu_issue_arbiter #(
    parameter int unsigned ALU_LAT = 1,
    parameter int unsigned MUL_LAT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [4:0]  req0_op,
    input  logic [31:0] req0_srca,
    input  logic [31:0] req0_srcb,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [4:0]  req1_op,
    input  logic [31:0] req1_srca,
    input  logic [31:0] req1_srcb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_dst,
    output logic [3:0]  rsp_sr,
    output logic [4:0]  alu_opMode,
    output logic [31:0] alu_srca,
    output logic [31:0] alu_srcb,
    output logic [3:0]  alu_sri,
    input  logic [31:0] alu_dst,
    input  logic [3:0]  alu_sro,
    input  logic        sr_wr_en,
    input  logic [3:0]  sr_wr_data,
    output logic [3:0]  sr
);

    localparam int unsigned MaxLat = (ALU_LAT > MUL_LAT) ? ALU_LAT : MUL_LAT;
    localparam int unsigned CntW   = (MaxLat > 1) ? $clog2(MaxLat) : 1;
    localparam logic [CntW-1:0] AluCnt = CntW'(ALU_LAT - 1);
    localparam logic [CntW-1:0] MulCnt = CntW'(MUL_LAT - 1);
    localparam logic [4:0] OpNone = 5'h00;
    localparam logic [4:0] OpMul  = 5'h03;

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_t;

    state_t          state_q;
    logic [CntW-1:0] cnt_q;
    logic            ptr_q;

    logic            grant0, grant1;
    logic [4:0]      win_op;
    logic [31:0]     win_srca, win_srcb;

    // On contention the requester not named by the pointer wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == StIdle) begin
            if (req0_valid && req1_valid) begin
                grant0 = ptr_q;
                grant1 = ~ptr_q;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign win_op     = grant1 ? req1_op   : req0_op;
    assign win_srca   = grant1 ? req1_srca : req0_srca;
    assign win_srcb   = grant1 ? req1_srcb : req0_srcb;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            ptr_q      <= 1'b0;
            sr         <= 4'h0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_dst    <= 32'h0;
            rsp_sr     <= 4'h0;
            alu_opMode <= OpNone;
            alu_srca   <= 32'h0;
            alu_srcb   <= 32'h0;
            alu_sri    <= 4'h0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (grant0 || grant1) begin
                        alu_opMode <= win_op;
                        alu_srca   <= win_srca;
                        alu_srcb   <= win_srcb;
                        alu_sri    <= sr;
                        rsp_id     <= grant1;
                        cnt_q      <= (win_op == OpMul) ? MulCnt : AluCnt;
                        if (req0_valid && req1_valid) begin
                            ptr_q <= grant1;
                        end
                        state_q    <= StExec;
                    end
                end
                StExec: begin
                    if (cnt_q == '0) begin
                        rsp_dst    <= alu_dst;
                        rsp_sr     <= alu_sro;
                        sr         <= alu_sro;
                        rsp_valid  <= 1'b1;
                        // The ALU only evaluates on opMode changes, so park it on NONE.
                        alu_opMode <= OpNone;
                        state_q    <= StResp;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase

            // External load beats a same-edge capture from the ALU.
            if (sr_wr_en) begin
                sr <= sr_wr_data;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Bench for alu_issue_arbiter: directed steps then randomized ops, checked against a
// transaction-level model of arbitration, latency and SR ownership.
module tb_alu_issue_arbiter;

    localparam int unsigned ALU_LAT = 1;
    localparam int unsigned MUL_LAT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [4:0]  req0_op = '0, req1_op = '0;
    logic [31:0] req0_srca = '0, req0_srcb = '0, req1_srca = '0, req1_srcb = '0;
    logic        req0_ready, req1_ready;
    logic        rsp_valid, rsp_id;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dst;
    logic [3:0]  rsp_sr;
    logic [4:0]  alu_opMode;
    logic [31:0] alu_srca, alu_srcb;
    logic [3:0]  alu_sri;
    logic [31:0] alu_dst = '0;
    logic [3:0]  alu_sro = '0;
    logic        sr_wr_en = 1'b0;
    logic [3:0]  sr_wr_data = '0;
    logic [3:0]  sr;

    int   tests = 0;
    int   fails = 0;
    logic [3:0] sr_m = '0;
    logic       ptr_m = 1'b0;
    logic [4:0] op_tab [7] = '{5'h01, 5'h02, 5'h03, 5'h14, 5'h1B, 5'h1F, 5'h07};

    alu_issue_arbiter #(.ALU_LAT(ALU_LAT), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_srca(req0_srca), .req0_srcb(req0_srcb),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_srca(req1_srca), .req1_srcb(req1_srcb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_dst(rsp_dst), .rsp_sr(rsp_sr),
        .alu_opMode(alu_opMode), .alu_srca(alu_srca), .alu_srcb(alu_srcb),
        .alu_sri(alu_sri), .alu_dst(alu_dst), .alu_sro(alu_sro),
        .sr_wr_en(sr_wr_en), .sr_wr_data(sr_wr_data), .sr(sr)
    );

    always #5 clk = ~clk;

    // Returns {sro, dst}. Unknown ops give dst=0 and pass SR through.
    function automatic logic [35:0] alu_fn(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [3:0] sri);
        logic [32:0] s;
        logic [31:0] d;
        logic [3:0]  so;
        s  = '0;
        d  = '0;
        so = sri;
        case (op)
            5'h01: begin s = {1'b0, a} + {1'b0, b}; d = s[31:0]; so = {sri[3:1], s[32]}; end
            5'h02: begin s = {1'b0, a} - {1'b0, b}; d = s[31:0]; so = {sri[3:1], s[32]}; end
            5'h03: d = a * b;
            5'h14: begin
                s = {1'b0, a} + {1'b0, b} + {32'h0, sri[0]};
                d = s[31:0];
                so = {sri[3:1], s[32]};
            end
            5'h1B: so = {sri[3:1], a == b};
            default: ;
        endcase
        return {so, d};
    endfunction

    // ALU stand-in that only re-evaluates when opMode changes.
    always @(alu_opMode) begin
        #1;
        {alu_sro, alu_dst} = alu_fn(alu_opMode, alu_srca, alu_srcb, alu_sri);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic sr_write(input logic [3:0] d);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        sr_wr_en   = 1'b1;
        sr_wr_data = d;
        tick();
        sr_wr_en = 1'b0;
        sr_m = d;
        chk("sr_write", 32'(sr), 32'(sr_m));
    endtask

    // Called from IDLE at 1 time unit after an edge; valids stay asserted throughout.
    task automatic run_op(input logic [1:0] vm,
                          input logic [4:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                          input logic [4:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                          input logic wr_g, input logic [3:0] dg,
                          input logic wr_c, input logic [3:0] dc, input int hold,
                          output logic w, output logic [31:0] dst_e, output logic [3:0] srr_e);
        logic [4:0]  op;
        logic [31:0] a, b;
        logic [3:0]  sri_e;
        logic [35:0] r;
        int          lat;
        req0_valid = vm[0]; req0_op = op0; req0_srca = a0; req0_srcb = b0;
        req1_valid = vm[1]; req1_op = op1; req1_srca = a1; req1_srcb = b1;
        rsp_ready  = 1'b0;
        sr_wr_en   = wr_g;
        sr_wr_data = dg;
        if (vm == 2'b11) begin
            w = ~ptr_m;
            ptr_m = w;
        end else begin
            w = vm[1];
        end
        #1;
        chk("req0_ready_grant", 32'(req0_ready), 32'(w == 1'b0));
        chk("req1_ready_grant", 32'(req1_ready), 32'(w == 1'b1));
        op    = w ? op1 : op0;
        a     = w ? a1 : a0;
        b     = w ? b1 : b0;
        sri_e = sr_m;
        lat   = (op == 5'h03) ? MUL_LAT : ALU_LAT;
        tick();
        sr_wr_en = 1'b0;
        if (wr_g) sr_m = dg;
        chk("alu_opMode_issue", 32'(alu_opMode), 32'(op));
        chk("alu_srca", alu_srca, a);
        chk("alu_srcb", alu_srcb, b);
        chk("alu_sri", 32'(alu_sri), 32'(sri_e));
        chk("sr_after_grant", 32'(sr), 32'(sr_m));
        chk("ready_exec", 32'({req1_ready, req0_ready}), 32'(0));
        for (int k = 1; k <= lat; k++) begin
            chk("rsp_valid_early", 32'(rsp_valid), 32'(0));
            chk("alu_opMode_hold", 32'(alu_opMode), 32'(op));
            if (k == lat) begin
                sr_wr_en   = wr_c;
                sr_wr_data = dc;
            end
            tick();
        end
        sr_wr_en = 1'b0;
        r     = alu_fn(op, a, b, sri_e);
        dst_e = r[31:0];
        srr_e = r[35:32];
        sr_m  = wr_c ? dc : srr_e;
        chk("rsp_valid_capture", 32'(rsp_valid), 32'(1));
        chk("rsp_id", 32'(rsp_id), 32'(w));
        chk("rsp_dst", rsp_dst, dst_e);
        chk("rsp_sr", 32'(rsp_sr), 32'(srr_e));
        chk("sr_capture", 32'(sr), 32'(sr_m));
        chk("alu_opMode_none", 32'(alu_opMode), 32'(0));
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("rsp_valid_hold", 32'(rsp_valid), 32'(1));
            chk("rsp_dst_hold", rsp_dst, dst_e);
            chk("rsp_sr_hold", 32'(rsp_sr), 32'(srr_e));
            chk("ready_resp", 32'({req1_ready, req0_ready}), 32'(0));
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", 32'(rsp_valid), 32'(0));
    endtask

    initial begin
        logic        w;
        logic [31:0] d;
        logic [3:0]  s;
        logic [1:0]  vm;

        #2 reset = 1'b0;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst_rsp_id", 32'(rsp_id), 32'(0));
        chk("rst_rsp_dst", rsp_dst, 32'h0);
        chk("rst_rsp_sr", 32'(rsp_sr), 32'(0));
        chk("rst_alu_opMode", 32'(alu_opMode), 32'(0));
        chk("rst_alu_srca", alu_srca, 32'h0);
        chk("rst_alu_srcb", alu_srcb, 32'h0);
        chk("rst_alu_sri", 32'(alu_sri), 32'(0));
        chk("rst_sr", 32'(sr), 32'(0));
        chk("rst_ready", 32'({req1_ready, req0_ready}), 32'(0));
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Single ADD from requester 0.
        run_op(2'b01, 5'h01, 32'd5, 32'd7, 5'h00, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 4'h0, 0,
               w, d, s);
        chk("add_id", 32'(w), 32'(0));
        chk("add_dst", d, 32'd12);

        // Contention: alternation starting with requester 1.
        for (int i = 0; i < 4; i++) begin
            run_op(2'b11, 5'h01, 32'(i), 32'd10, 5'h01, 32'(100 + i), 32'd1,
                   1'b0, 4'h0, 1'b0, 4'h0, 0, w, d, s);
            chk("rr_order", 32'(w), 32'((i % 2) == 0));
        end

        // ADD then MUL from requester 1.
        run_op(2'b10, 5'h00, 32'h0, 32'h0, 5'h01, 32'd2, 32'd3, 1'b0, 4'h0, 1'b0, 4'h0, 0,
               w, d, s);
        chk("pre_mul_add", d, 32'd5);
        run_op(2'b10, 5'h00, 32'h0, 32'h0, 5'h03, 32'h0001_0000, 32'h10,
               1'b0, 4'h0, 1'b0, 4'h0, 0, w, d, s);
        chk("mul_dst", d, 32'h0010_0000);

        // ADDC chain through the SR carry.
        sr_write(4'h1);
        run_op(2'b01, 5'h14, 32'hFFFF_FFFF, 32'h0, 5'h00, 32'h0, 32'h0,
               1'b0, 4'h0, 1'b0, 4'h0, 0, w, d, s);
        chk("addc1_dst", d, 32'h0);
        chk("addc1_c", 32'(sr[0]), 32'(1));
        run_op(2'b01, 5'h14, 32'd1, 32'd1, 5'h00, 32'h0, 32'h0,
               1'b0, 4'h0, 1'b0, 4'h0, 0, w, d, s);
        chk("addc2_dst", d, 32'd3);

        // Consumer stalls 5 cycles while requester 0 keeps asking.
        run_op(2'b01, 5'h02, 32'd9, 32'd4, 5'h00, 32'h0, 32'h0,
               1'b0, 4'h0, 1'b0, 4'h0, 5, w, d, s);
        chk("idle_after_resp", 32'(req0_ready), 32'(1));

        // Leave pointer at 1 and SR nonzero, then reset mid-MUL.
        run_op(2'b11, 5'h01, 32'd1, 32'd1, 5'h01, 32'd2, 32'd2,
               1'b0, 4'h0, 1'b0, 4'h0, 0, w, d, s);
        chk("pre_reset_id", 32'(w), 32'(1));
        sr_write(4'h6);
        req1_valid = 1'b1; req1_op = 5'h03; req1_srca = 32'd7; req1_srcb = 32'd9;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("abort_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("abort_sr", 32'(sr), 32'(0));
        chk("abort_opMode", 32'(alu_opMode), 32'(0));
        req1_valid = 1'b0;
        #1 reset = 1'b1;
        ptr_m = 1'b0;
        sr_m  = 4'h0;
        run_op(2'b11, 5'h01, 32'd40, 32'd2, 5'h01, 32'd30, 32'd3,
               1'b0, 4'h0, 1'b0, 4'h0, 0, w, d, s);
        chk("post_reset_id", 32'(w), 32'(1));
        chk("post_reset_dst", d, 32'd33);

        // SR load on the capture edge of CMPEQ.
        run_op(2'b01, 5'h1B, 32'h55, 32'h55, 5'h00, 32'h0, 32'h0,
               1'b0, 4'h0, 1'b1, 4'hC, 0, w, d, s);
        chk("cmpeq_sr", 32'(sr), 32'hC);
        chk("cmpeq_rsp_sr0", 32'(s[0]), 32'(1));

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
                #1;
                chk("idle_ready", 32'({req1_ready, req0_ready}), 32'(0));
                tick();
                chk("idle_rsp_valid", 32'(rsp_valid), 32'(0));
            end else begin
                vm = 2'($urandom_range(1, 3));
                run_op(vm, op_tab[$urandom_range(0, 6)], $urandom(), $urandom(),
                       op_tab[$urandom_range(0, 6)], $urandom(), $urandom(),
                       ($urandom_range(0, 3) == 0), 4'($urandom()),
                       ($urandom_range(0, 3) == 0), 4'($urandom()),
                       $urandom_range(0, 3), w, d, s);
            end
        end

        req0_valid = 1'b0;
        req1_valid = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
